counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4: number of ring stages and output width; legal range 2 to 32.
REQ-002 Parameter INIT, default 4'b1000 (WIDTH bits, MSB set): one-hot pattern loaded by clear; must contain exactly one 1.
REQ-003 Parameter DIR, default 0: rotation direction; 0 = rotate right (toward bit 0), 1 = rotate left (toward MSB).
REQ-004 clk    input   1      single clock; all state changes on rising edge.
REQ-005 clear  input   1      synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-006 out    output  WIDTH  ring state, driven directly from the state register with no combinational path from inputs.

Function
REQ-007 Rising clk with clear=1 SHALL load out <= INIT, regardless of current state.
REQ-008 Rising clk with clear=0, DIR=0 SHALL set out <= {out[0], out[WIDTH-1:1]}.
REQ-009 Rising clk with clear=0, DIR=1 SHALL set out <= {out[WIDTH-2:0], out[WIDTH-1]}.
REQ-010 Sequence for defaults after clear: 1000 -> 0100 -> 0010 -> 0001 -> 1000; period WIDTH cycles.
REQ-011 Wrap-around: the bit leaving one end SHALL enter the opposite end in the same cycle; no cycle is lost.
REQ-012 Latency: out reflects clear or rotation one clock after the sampling edge; no other pipeline.
REQ-013 clear asserted mid-sequence SHALL override rotation on that edge; rotation resumes from INIT on the first edge with clear=0.
REQ-014 clear held high for N edges SHALL hold out at INIT for all N edges.
REQ-015 Exactly one bit of out SHALL be 1 in every cycle after the first clear (one-hot invariant), absent REQ-019 corrections.

Reset
REQ-016 Reset value of out: INIT (1000 for defaults); there is no asynchronous reset path.
REQ-017 Before the first clear edge out is undefined (X in simulation), except as provided by REQ-019.
REQ-018 clear has no effect between clock edges; a pulse not covering a rising edge is ignored.

Configuration
REQ-019 Macro COUNTER_SELF_CORRECT_EN: when defined, on any rising edge with clear=0 where out is not exactly one-hot (zero bits set, or two or more set), out SHALL be loaded with INIT instead of rotating; X/unknown state is likewise treated as illegal.
REQ-020 Without COUNTER_SELF_CORRECT_EN, the counter SHALL rotate any state unmodified (e.g. 0000 stays 0000, 1010 -> 0101 -> 1010) and only clear restores one-hot.

Verification
REQ-021 Clock 10-unit period, clear=1 across edge at t=15 -> out=1000 at t=15.
REQ-022 clear=0 for edges t=25,35,45,55,65 -> out 0100, 0010, 0001, 1000, 0100 (wrap verified).
REQ-023 clear=1 across edge t=75 mid-sequence -> out=1000; edges t=85,95 with clear=0 -> 0100, 0010.
REQ-024 clear held high for 3 consecutive edges -> out stays 1000 on each; first edge after release -> 0100.
REQ-025 DIR=1, WIDTH=4, INIT=0001 -> after clear: 0001, 0010, 0100, 1000, 0001.
REQ-026 With COUNTER_SELF_CORRECT_EN, force out=0110, clear=0 -> next edge out=1000; without macro -> next edge 0011.

Source files
------------

// File: rtl/counter.sv
// counter: WIDTH-stage one-hot ring counter with synchronous active-high clear.
// clear loads INIT; otherwise the ring rotates one position per clock
// (DIR=0 toward bit 0, DIR=1 toward the MSB), with the bit leaving one end
// entering the opposite end on the same edge.
// Optional build macro COUNTER_SELF_CORRECT_EN: any state that is not exactly
// one-hot (including unknown) is replaced by INIT instead of being rotated.
module counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = {1'b1, {(WIDTH-1){1'b0}}},
  parameter bit               DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] rotated;

  // Next ring state for one step of rotation in the configured direction.
  always_comb begin
    if (DIR) rotated = {out[WIDTH-2:0], out[WIDTH-1]};
    else     rotated = {out[0], out[WIDTH-1:1]};
  end

`ifdef COUNTER_SELF_CORRECT_EN

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] ones;
  logic          legal;

  // Population count of the ring; legal only when exactly one bit is set.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(out[i]);
    end
    legal = (ones == CW'(1));
  end

  // Rotate only a clean one-hot state; clear or an illegal state loads INIT.
  // An unknown legal flag takes the else branch, so X state also loads INIT.
  always_ff @(posedge clk) begin
    if (!clear && legal) out <= rotated;
    else                 out <= INIT;
  end

`else

  // Clear loads INIT; otherwise rotate whatever pattern is held.
  always_ff @(posedge clk) begin
    if (clear) out <= INIT;
    else       out <= rotated;
  end

`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: self-checking bench for counter. A right-rotating default
// instance and a left-rotating INIT=0001 instance share clk and clear; the
// reference model tracks the index of the hot bit for each ring.
module tb_counter;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         clear = 1'b1;
  logic [W-1:0] out0;
  logic [W-1:0] out1;

  int total = 0;
  int bad   = 0;
  int p0    = W - 1;
  int p1    = 0;

  counter #(.WIDTH(W)) u0 (
    .clk   (clk),
    .clear (clear),
    .out   (out0)
  );

  counter #(.WIDTH(W), .INIT(4'b0001), .DIR(1'b1)) u1 (
    .clk   (clk),
    .clear (clear),
    .out   (out1)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] hot(input int p);
    logic [W-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Reference for an arbitrary pattern on the right-rotating default ring.
  function automatic logic [W-1:0] ref_step0(input logic [W-1:0] v);
    int unsigned n;
    logic [W-1:0] r;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    r = (v >> 1) | (v[0] ? hot(W - 1) : '0);
`ifdef COUNTER_SELF_CORRECT_EN
    if (n != 1) r = hot(W - 1);
`endif
    return r;
  endfunction

  // Apply clear value across one rising edge and advance the model.
  task automatic tick(input logic c);
    clear = c;
    @(posedge clk);
    #1;
    if (c) begin
      p0 = W - 1;
      p1 = 0;
    end else begin
      p0 = (p0 + W - 1) % W;
      p1 = (p1 + 1) % W;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      total++;
      if (out0 !== hot(p0)) begin
        bad++;
        $display("FAIL reset_hold0[%0d] got=%b want=%b", i, out0, hot(p0));
      end
      total++;
      if (out1 !== hot(p1)) begin
        bad++;
        $display("FAIL reset_hold1[%0d] got=%b want=%b", i, out1, hot(p1));
      end
    end
    tick(1'b0);
    total++;
    if (out0 !== 4'b0100) begin
      bad++;
      $display("FAIL release0 got=%b want=0100", out0);
    end
    total++;
    if (out1 !== 4'b0010) begin
      bad++;
      $display("FAIL release1 got=%b want=0010", out1);
    end
  endtask

  task automatic test_sequence;
    tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      total++;
      if (out0 !== hot(p0)) begin
        bad++;
        $display("FAIL seq0[%0d] got=%b want=%b", i, out0, hot(p0));
      end
      total++;
      if (out1 !== hot(p1)) begin
        bad++;
        $display("FAIL seq1[%0d] got=%b want=%b", i, out1, hot(p1));
      end
    end
  endtask

  task automatic test_midclear;
    tick(1'b0);
    tick(1'b1);
    total++;
    if (out0 !== 4'b1000) begin
      bad++;
      $display("FAIL midclear0 got=%b want=1000", out0);
    end
    total++;
    if (out1 !== 4'b0001) begin
      bad++;
      $display("FAIL midclear1 got=%b want=0001", out1);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      total++;
      if (out0 !== hot(p0)) begin
        bad++;
        $display("FAIL resume0[%0d] got=%b want=%b", i, out0, hot(p0));
      end
    end
  endtask

  task automatic test_glitch;
    tick(1'b0);
    @(negedge clk);
    clear = 1'b1;
    #2;
    clear = 1'b0;
    tick(1'b0);
    total++;
    if (out0 !== hot(p0)) begin
      bad++;
      $display("FAIL glitch0 got=%b want=%b", out0, hot(p0));
    end
    total++;
    if (out1 !== hot(p1)) begin
      bad++;
      $display("FAIL glitch1 got=%b want=%b", out1, hot(p1));
    end
  endtask

  task automatic test_random;
    tick(1'b1);
    for (int i = 0; i < 200; i++) begin
      tick($urandom_range(0, 3) == 0);
      total++;
      if (out0 !== hot(p0)) begin
        bad++;
        $display("FAIL rand0[%0d] got=%b want=%b", i, out0, hot(p0));
      end
      total++;
      if (out1 !== hot(p1)) begin
        bad++;
        $display("FAIL rand1[%0d] got=%b want=%b", i, out1, hot(p1));
      end
    end
  endtask

  task automatic test_nonhot;
    logic [W-1:0] pats [3];
    logic [W-1:0] exp;
    pats[0] = 4'b0110;
    pats[1] = 4'b1010;
    pats[2] = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1);
      clear = 1'b0;
      @(negedge clk);
      force u0.out = pats[k];
      #1;
      release u0.out;
      #1;
      if (out0 === pats[k]) begin
        exp = pats[k];
        for (int s = 0; s < 2; s++) begin
          tick(1'b0);
          exp = ref_step0(exp);
          total++;
          if (out0 !== exp) begin
            bad++;
            $display("FAIL nonhot[%0d.%0d] got=%b want=%b", k, s, out0, exp);
          end
        end
      end else begin
        $display("note: forced pattern %b not retained, step skipped", pats[k]);
      end
    end
    tick(1'b1);
  endtask

  initial begin
    tick(1'b1);
    test_reset;
    test_sequence;
    test_midclear;
    test_glitch;
    test_random;
    test_nonhot;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
